// File: rtl/snes_joy_pkg.sv
// Shared constants and types for the SNES joypad port responder.
// Button indices follow the order in which the pad shifts them out.
package snes_joy_pkg;

    localparam int BTN_B_IDX      = 0;
    localparam int BTN_Y_IDX      = 1;
    localparam int BTN_SELECT_IDX = 2;
    localparam int BTN_START_IDX  = 3;
    localparam int BTN_UP_IDX     = 4;
    localparam int BTN_DOWN_IDX   = 5;
    localparam int BTN_LEFT_IDX   = 6;
    localparam int BTN_RIGHT_IDX  = 7;
    localparam int BTN_A_IDX      = 8;
    localparam int BTN_X_IDX      = 9;
    localparam int BTN_L_IDX      = 10;
    localparam int BTN_R_IDX      = 11;

    localparam int          FRAME_LEN = 16;
    localparam int          CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = 5'd16;
    localparam logic [3:0]  PAD_ID    = 4'b0000;

    typedef logic [11:0] pad_btn_t;

    // Serial frame as seen by the console: buttons first, ID nibble last.
    function automatic logic [FRAME_LEN-1:0] pad_frame(input pad_btn_t btn);
        return {PAD_ID, btn};
    endfunction

endpackage

// File: rtl/snes_joypad_port_if.sv
// Joypad port bundle: core-side strobe/clock/select, frontend buttons,
// and the serial data / bit count returned by the port.
interface snes_joypad_port_if;
    import snes_joy_pkg::*;

    logic        JOY_STRB;
    logic        JOY_CLK;
    logic        JOY_P6;
    pad_btn_t    BTN_A;
    pad_btn_t    BTN_B;
    pad_btn_t    BTN_C;
    pad_btn_t    BTN_D;
    logic [1:0]  JOY_DI;
    logic [4:0]  BIT_CNT;

    modport master (
        output JOY_STRB, JOY_CLK, JOY_P6, BTN_A, BTN_B, BTN_C, BTN_D,
        input  JOY_DI, BIT_CNT
    );

    modport slave (
        input  JOY_STRB, JOY_CLK, JOY_P6, BTN_A, BTN_B, BTN_C, BTN_D,
        output JOY_DI, BIT_CNT
    );
endinterface

// File: rtl/snes_pad_shifter.sv
// One pad's 16-bit parallel-load shift register; shifts right with a 1 fill
// so the line reads pressed-high 1s once the frame is exhausted.
module snes_pad_shifter
    import snes_joy_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift,
    input  logic [FRAME_LEN-1:0] frame,
    output logic                 q0
);

    logic [FRAME_LEN-1:0] sr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= frame;
        end else if (shift) begin
            sr_reg <= {1'b1, sr_reg[FRAME_LEN-1:1]};
        end
    end

    assign q0 = sr_reg[0];

endmodule

// File: rtl/snes_joypad_port.sv
// SNES controller-port responder: one pad, or four pads behind a multitap
// when SNES_MULTITAP_EN is defined (P6 then selects pair A/B or C/D).
module snes_joypad_port
    import snes_joy_pkg::*;
(
    input  logic                MCLK,
    input  logic                RESET_N,
    snes_joypad_port_if.slave   bus
);

`ifdef SNES_MULTITAP_EN
    localparam int NPADS  = 4;
    localparam int NPAIRS = 2;
`else
    localparam int NPADS  = 1;
    localparam int NPAIRS = 1;
`endif

    logic strb_q, clk_q, clk_qq, p6_q;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strb_q <= 1'b0;
            clk_q  <= 1'b0;
            clk_qq <= 1'b0;
            p6_q   <= 1'b0;
        end else begin
            strb_q <= bus.JOY_STRB;
            clk_q  <= bus.JOY_CLK;
            clk_qq <= clk_q;
            p6_q   <= bus.JOY_P6;
        end
    end

    // Strobe has priority: a clock edge seen during load is discarded.
    logic shift_ok;
    assign shift_ok = clk_q & ~clk_qq & ~strb_q;

    pad_btn_t          btn [NPADS];
    logic [NPADS-1:0]  pad_shift;
    logic [NPADS-1:0]  pad_q0;
    logic [NPAIRS-1:0] pair_shift;
    logic [CNT_W-1:0]  cnt_reg [NPAIRS];

    generate
        for (genvar gi = 0; gi < NPADS; gi++) begin : g_pad
            snes_pad_shifter u_shifter (
                .clk   (MCLK),
                .rst_n (RESET_N),
                .load  (strb_q),
                .shift (pad_shift[gi]),
                .frame (pad_frame(btn[gi])),
                .q0    (pad_q0[gi])
            );
        end
    endgenerate

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NPAIRS; i++) cnt_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NPAIRS; i++) begin
                if (strb_q) begin
                    cnt_reg[i] <= '0;
                end else if (pair_shift[i] && cnt_reg[i] != CNT_MAX) begin
                    cnt_reg[i] <= cnt_reg[i] + 5'd1;
                end
            end
        end
    end

`ifdef SNES_MULTITAP_EN
    assign btn[0] = bus.BTN_A;
    assign btn[1] = bus.BTN_B;
    assign btn[2] = bus.BTN_C;
    assign btn[3] = bus.BTN_D;

    // Pair 0 is A/B (P6 high), pair 1 is C/D (P6 low).
    assign pair_shift = {shift_ok & ~p6_q, shift_ok & p6_q};
    assign pad_shift  = {pair_shift[1], pair_shift[1], pair_shift[0], pair_shift[0]};

    // D1 held high during strobe lets the console detect the tap.
    assign bus.JOY_DI[0] = p6_q ? pad_q0[0] : pad_q0[2];
    assign bus.JOY_DI[1] = strb_q | (p6_q ? pad_q0[1] : pad_q0[3]);
    assign bus.BIT_CNT   = p6_q ? cnt_reg[0] : cnt_reg[1];
`else
    assign btn[0]     = bus.BTN_A;
    assign pair_shift = shift_ok;
    assign pad_shift  = shift_ok;

    assign bus.JOY_DI  = {1'b0, pad_q0[0]};
    assign bus.BIT_CNT = cnt_reg[0];

    wire unused_inputs = &{1'b0, p6_q, bus.BTN_B, bus.BTN_C, bus.BTN_D};
`endif

endmodule

// File: tb/tb_snes_joypad_port.sv
// Self-checking bench for snes_joypad_port; multitap checks are compiled
// in when SNES_MULTITAP_EN is defined.
module tb_snes_joypad_port;
    import snes_joy_pkg::*;

    logic MCLK    = 1'b0;
    logic RESET_N = 1'b0;

    snes_joypad_port_if bus();

    snes_joypad_port dut (
        .MCLK    (MCLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 MCLK = ~MCLK;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        pad_btn_t   btn;
        int         shifts;
        logic       di0;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic strobe(input int n);
        bus.JOY_STRB = 1'b1;
        cyc(n);
        bus.JOY_STRB = 1'b0;
        cyc(3);
    endtask

    task automatic pulse();
        bus.JOY_CLK = 1'b0;
        cyc(2);
        bus.JOY_CLK = 1'b1;
        cyc(3);
    endtask

    // Reference: k-th serial bit the console sees after a latch of btn.
    function automatic logic ref_bit(input pad_btn_t b, input int k);
        logic [15:0] f;
        f = {4'b0000, b};
        if (k >= 16) return 1'b1;
        return f[k];
    endfunction

    function automatic logic [15:0] ref_cnt(input int s);
        return (s > 16) ? 16'd16 : 16'(s);
    endfunction

    task automatic full_read(input pad_btn_t b, input string tag);
        bus.BTN_A = b;
        strobe(4);
        chk($sformatf("%s bit0", tag), 16'(bus.JOY_DI[0]), 16'(ref_bit(b, 0)));
        chk($sformatf("%s cnt0", tag), 16'(bus.BIT_CNT), 16'd0);
        for (int s = 1; s <= 17; s++) begin
            pulse();
            chk($sformatf("%s bit%0d", tag, s), 16'(bus.JOY_DI[0]), 16'(ref_bit(b, s)));
            chk($sformatf("%s cnt%0d", tag, s), 16'(bus.BIT_CNT), ref_cnt(s));
`ifndef SNES_MULTITAP_EN
            chk($sformatf("%s d1_%0d", tag, s), 16'(bus.JOY_DI[1]), 16'd0);
`endif
        end
    endtask

    initial begin
        pad_btn_t rb;

        tbl[0] = '{12'h001, 0,  1'b1, 5'd0};
        tbl[1] = '{12'h001, 1,  1'b0, 5'd1};
        tbl[2] = '{12'h001, 15, 1'b0, 5'd15};
        tbl[3] = '{12'h001, 16, 1'b1, 5'd16};
        tbl[4] = '{12'h001, 17, 1'b1, 5'd16};
        tbl[5] = '{12'hC00, 9,  1'b0, 5'd9};
        tbl[6] = '{12'hC00, 10, 1'b1, 5'd10};
        tbl[7] = '{12'hC00, 11, 1'b1, 5'd11};
        tbl[8] = '{12'hC00, 12, 1'b0, 5'd12};
        tbl[9] = '{12'hFFF, 15, 1'b0, 5'd15};

        bus.JOY_STRB = 1'b0;
        bus.JOY_CLK  = 1'b1;
        bus.JOY_P6   = 1'b1;
        bus.BTN_A    = '0;
        bus.BTN_B    = 12'hFFF;
        bus.BTN_C    = 12'hFFF;
        bus.BTN_D    = 12'hFFF;

        cyc(2);
        chk("reset di", 16'(bus.JOY_DI), 16'd0);
        chk("reset cnt", 16'(bus.BIT_CNT), 16'd0);
        RESET_N = 1'b1;
        cyc(3);

        for (int i = 0; i < 10; i++) begin
            bus.BTN_A = tbl[i].btn;
            strobe(4);
            repeat (tbl[i].shifts) pulse();
            chk($sformatf("tbl%0d di0", i), 16'(bus.JOY_DI[0]), 16'(tbl[i].di0));
            chk($sformatf("tbl%0d cnt", i), 16'(bus.BIT_CNT), 16'(tbl[i].cnt));
        end

        full_read(12'h001, "b_only");
        full_read(12'hC00, "l_r");

        // Strobe held while the core clocks: output tracks BTN_A[0], no count.
        bus.JOY_STRB = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.BTN_A = 12'($urandom_range(0, 4095));
            bus.JOY_CLK = 1'b0;
            cyc(2);
            bus.JOY_CLK = 1'b1;
            cyc(3);
            chk($sformatf("strb_hold%0d di0", i), 16'(bus.JOY_DI[0]), 16'(bus.BTN_A[0]));
            chk($sformatf("strb_hold%0d cnt", i), 16'(bus.BIT_CNT), 16'd0);
        end
        bus.JOY_STRB = 1'b0;
        cyc(3);

        for (int r = 0; r < 8; r++) begin
            rb = 12'($urandom_range(0, 4095));
            bus.BTN_B = 12'($urandom_range(0, 4095));
            full_read(rb, $sformatf("rnd%0d", r));
        end

        // Reset mid-read: bit 5 of the frame is 1 so the drop is visible.
        bus.BTN_A = 12'h020;
        strobe(4);
        repeat (5) pulse();
        chk("pre_rst di0", 16'(bus.JOY_DI[0]), 16'd1);
        @(posedge MCLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst di", 16'(bus.JOY_DI), 16'd0);
        chk("async_rst cnt", 16'(bus.BIT_CNT), 16'd0);
        cyc(2);
        RESET_N = 1'b1;
        cyc(4);
        chk("post_rst di", 16'(bus.JOY_DI), 16'd0);
        full_read(12'h5A3, "after_rst");

`ifdef SNES_MULTITAP_EN
        bus.BTN_A  = 12'h001;
        bus.BTN_B  = 12'h000;
        bus.BTN_C  = 12'h004;
        bus.BTN_D  = 12'h008;
        bus.JOY_P6 = 1'b1;
        bus.JOY_STRB = 1'b1;
        cyc(3);
        chk("tap_detect b0", 16'(bus.JOY_DI[1]), 16'd1);
        bus.BTN_B = 12'h002;
        cyc(2);
        chk("tap_detect b2", 16'(bus.JOY_DI[1]), 16'd1);
        bus.JOY_STRB = 1'b0;
        cyc(3);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) pulse();
            chk($sformatf("tapAB bit%0d d0", k), 16'(bus.JOY_DI[0]), 16'(ref_bit(12'h001, k)));
            chk($sformatf("tapAB bit%0d d1", k), 16'(bus.JOY_DI[1]), 16'(ref_bit(12'h002, k)));
        end
        bus.JOY_P6 = 1'b0;
        cyc(2);
        for (int k = 0; k < 16; k++) begin
            if (k > 0) pulse();
            chk($sformatf("tapCD bit%0d d0", k), 16'(bus.JOY_DI[0]), 16'(ref_bit(12'h004, k)));
            chk($sformatf("tapCD bit%0d d1", k), 16'(bus.JOY_DI[1]), 16'(ref_bit(12'h008, k)));
            chk($sformatf("tapCD cnt%0d", k), 16'(bus.BIT_CNT), 16'(k));
        end
        bus.JOY_P6 = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
